// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the four-bus I2C arbiter.
// Bus indices match the physical harness numbering.
package i2c_arb_pkg;

   localparam int NUM_BUS = 4;
   localparam int IDX_W   = 2;

   localparam logic [IDX_W-1:0] BUS_CAP_SENSE = 2'd0;
   localparam logic [IDX_W-1:0] BUS_LIGHT     = 2'd1;
   localparam logic [IDX_W-1:0] BUS_RH_TEMP   = 2'd2;
   localparam logic [IDX_W-1:0] BUS_PMONITOR  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_DRAIN,
      ST_GUARD
   } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request after last,
// wrapping; the last index itself has the lowest priority.
module rr_priority_pick
   import i2c_arb_pkg::*;
(
   input  logic [NUM_BUS-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] cand;

   // Scan farthest-first so the nearest hit after last wins.
   always_comb begin
      valid = 1'b0;
      idx   = last;
      cand  = last;
      for (int off = NUM_BUS; off >= 1; off--) begin
         cand = last + IDX_W'(off);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master across four physical buses with
// round-robin grants, a busy drain, a guard gap and a watchdog.
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned GUARD_CYCLES   = 16
)
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_BUS-1:0] i_req,
   output logic [NUM_BUS-1:0] o_grant,
   output logic [IDX_W-1:0]   o_sel,
   output logic               o_timeout,
   input  logic               i_master_busy,
   input  logic               i_m_scl_oe,
   input  logic               i_m_sda_oe,
   output logic               o_m_scl_i,
   output logic               o_m_sda_i,
   input  logic [NUM_BUS-1:0] i_bus_scl_i,
   input  logic [NUM_BUS-1:0] i_bus_sda_i,
   output logic [NUM_BUS-1:0] o_bus_scl_o,
   output logic [NUM_BUS-1:0] o_bus_sda_o,
   output logic [NUM_BUS-1:0] o_bus_scl_oe,
   output logic [NUM_BUS-1:0] o_bus_sda_oe
);

   localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W  = (TW_RAW < 1) ? 1 : TW_RAW;
   localparam logic [CNT_W-1:0] T_LIM   = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam int G_CYC  = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
   localparam int GW_RAW = $clog2(G_CYC + 1);
   localparam int GW     = (GW_RAW < 1) ? 1 : GW_RAW;
   localparam logic [GW-1:0] G_LAST = GW'(G_CYC - 1);

   arb_state_e         state_q, state_d;
   logic [NUM_BUS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   wdog_q, wdog_d, wdog_inc;
   logic [GW-1:0]      gcnt_q, gcnt_d;
   logic               timeout_q, timeout_d;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic               route;

   rr_priority_pick u_pick (
      .req   (i_req),
      .last  (last_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         sel_q     <= '0;
         last_q    <= BUS_PMONITOR;
         wdog_q    <= '0;
         gcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         wdog_q    <= wdog_d;
         gcnt_q    <= gcnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Saturating watchdog increment.
   assign wdog_inc = (wdog_q == CNT_MAX) ? wdog_q : wdog_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      sel_d     = sel_q;
      last_d    = last_q;
      wdog_d    = wdog_q;
      gcnt_d    = gcnt_q;
      timeout_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d           = ST_ACTIVE;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               sel_d             = pick_idx;
               last_d            = pick_idx;
               wdog_d            = '0;
            end
         end
         ST_ACTIVE: begin
            if (!i_req[sel_q]) begin
               state_d = ST_DRAIN;
               grant_d = '0;
            end else begin
               wdog_d = wdog_inc;
               if (TIMEOUT_CYCLES != 0 && wdog_inc == T_LIM) begin
                  state_d   = ST_DRAIN;
                  grant_d   = '0;
                  timeout_d = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (!i_master_busy) begin
               state_d = ST_GUARD;
               gcnt_d  = '0;
            end
         end
         ST_GUARD: begin
            if (gcnt_q == G_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gcnt_d = gcnt_q + GW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign route = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);

   // Idle lines read as released (high) back at the master.
   always_comb begin
      o_bus_scl_oe = '0;
      o_bus_sda_oe = '0;
      o_m_scl_i    = 1'b1;
      o_m_sda_i    = 1'b1;
      if (route) begin
         o_bus_scl_oe[sel_q] = i_m_scl_oe;
         o_bus_sda_oe[sel_q] = i_m_sda_oe;
         o_m_scl_i           = i_bus_scl_i[sel_q];
         o_m_sda_i           = i_bus_sda_i[sel_q];
      end
   end

   assign o_bus_scl_o = '0;
   assign o_bus_sda_o = '0;
   assign o_grant     = grant_q;
   assign o_sel       = sel_q;
   assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench: stimulus queues expected grants and timeouts,
// a negedge monitor pops and compares as the DUT presents them.
module tb_i2c_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       tmo;
   logic       busy = 1'b0;
   logic       m_scl_oe = 1'b0;
   logic       m_sda_oe = 1'b0;
   logic       m_scl_i, m_sda_i;
   logic [3:0] bus_scl_i = 4'hf;
   logic [3:0] bus_sda_i = 4'hf;
   logic [3:0] bus_scl_o, bus_sda_o, bus_scl_oe, bus_sda_oe;

   typedef struct {
      logic [3:0] g;
      logic [1:0] s;
      int         gap;
   } gexp_t;

   gexp_t      exp_q[$];
   int         to_q[$];
   int         total = 0;
   int         bad = 0;
   int         zeros = 0;
   int         hi = 0;
   logic [3:0] prev_g = '0;

   always #5 clk = ~clk;

   i2c_bus_arbiter #(
      .TIMEOUT_CYCLES(100),
      .GUARD_CYCLES(16)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_req(req),
      .o_grant(grant),
      .o_sel(sel),
      .o_timeout(tmo),
      .i_master_busy(busy),
      .i_m_scl_oe(m_scl_oe),
      .i_m_sda_oe(m_sda_oe),
      .o_m_scl_i(m_scl_i),
      .o_m_sda_i(m_sda_i),
      .i_bus_scl_i(bus_scl_i),
      .i_bus_sda_i(bus_sda_i),
      .o_bus_scl_o(bus_scl_o),
      .o_bus_sda_o(bus_sda_o),
      .o_bus_scl_oe(bus_scl_oe),
      .o_bus_sda_oe(bus_sda_oe)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic push_g(input logic [3:0] g, input logic [1:0] s,
                         input int gap);
      gexp_t e;
      e.g = g;
      e.s = s;
      e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic wait_grant(input logic [3:0] g, input int limit);
      int n = 0;
      while (grant !== g && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (grant !== g) begin
         total++;
         bad++;
         $display("FAIL wait_grant: got %0h want %0h", grant, g);
      end
   endtask

   // Monitor: grant rising edges and timeout pulses.
   always @(negedge clk) begin
      gexp_t e;
      if (!rst_n) begin
         zeros = 0;
         hi = 0;
         prev_g = grant;
      end else begin
         chk("onehot0", 32'($onehot0(grant)), 1);
         if (grant != 0 && prev_g == 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_grant", 32'(grant), 0);
            end else begin
               e = exp_q.pop_front();
               chk("grant", 32'(grant), 32'(e.g));
               chk("sel", 32'(sel), 32'(e.s));
               if (e.gap >= 0) chk("gap", zeros, e.gap);
            end
            hi = 0;
            zeros = 0;
         end
         if (grant != 0) hi++;
         else zeros++;
         if (tmo) begin
            if (to_q.size() == 0) chk("unexpected_timeout", 32'(tmo), 0);
            else chk("timeout_len", hi, to_q.pop_front());
         end
         prev_g = grant;
      end
   end

   initial begin
      // Reset values.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_tmo", 32'(tmo), 0);
      chk("rst_scl_oe", 32'(bus_scl_oe), 0);
      chk("rst_m_scl_i", 32'(m_scl_i), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Bus 0 first, then bus 2 after drain and guard.
      @(negedge clk);
      push_g(4'b0001, 2'd0, -1);
      req = 4'b0101;
      @(negedge clk);
      chk("first_latency", 32'(grant), 32'(4'b0001));
      repeat (4) @(negedge clk);
      push_g(4'b0100, 2'd2, 18);
      req = 4'b0100;
      wait_grant(4'b0100, 100);
      req = 4'b0000;
      repeat (25) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // All four requesting: full rotation, re-requests in drain.
      @(negedge clk);
      push_g(4'b0001, 2'd0, -1);
      push_g(4'b0010, 2'd1, 18);
      push_g(4'b0100, 2'd2, 18);
      push_g(4'b1000, 2'd3, 18);
      push_g(4'b0001, 2'd0, 18);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant(4'(1 << (k % 4)), 200);
         repeat (10) @(negedge clk);
         req[k % 4] = 1'b0;
         @(negedge clk);
         req[k % 4] = 1'b1;
      end
      req = 4'b0000;
      repeat (25) @(negedge clk);

      // Bus 1 routing, then a 50-cycle busy drain.
      push_g(4'b0010, 2'd1, -1);
      req = 4'b0010;
      wait_grant(4'b0010, 50);
      m_scl_oe = 1'b1;
      m_sda_oe = 1'b0;
      bus_scl_i = 4'b1101;
      bus_sda_i = 4'b1101;
      #1;
      chk("route_scl_oe", 32'(bus_scl_oe), 32'(4'b0010));
      chk("route_sda_oe", 32'(bus_sda_oe), 0);
      chk("route_m_scl_i", 32'(m_scl_i), 0);
      chk("route_m_sda_i0", 32'(m_sda_i), 0);
      bus_sda_i = 4'b0010;
      m_sda_oe = 1'b1;
      #1;
      chk("route_m_sda_i1", 32'(m_sda_i), 1);
      chk("route_sda_oe1", 32'(bus_sda_oe), 32'(4'b0010));
      @(negedge clk);
      busy = 1'b1;
      req = 4'b0000;
      @(negedge clk);
      chk("drain_grant", 32'(grant), 0);
      chk("drain_oe_first", 32'(bus_scl_oe), 32'(4'b0010));
      repeat (49) @(negedge clk);
      chk("drain_oe_last", 32'(bus_scl_oe), 32'(4'b0010));
      busy = 1'b0;
      @(negedge clk);
      chk("guard_scl_oe", 32'(bus_scl_oe), 0);
      chk("guard_sda_oe", 32'(bus_sda_oe), 0);
      chk("guard_m_sda_i", 32'(m_sda_i), 1);
      bus_scl_i = 4'b0000;
      bus_sda_i = 4'b0000;
      repeat (20) @(negedge clk);
      #1;
      chk("idle_m_scl_i", 32'(m_scl_i), 1);
      chk("idle_m_sda_i", 32'(m_sda_i), 1);

      // Watchdog on bus 2, then round-robin moves on to bus 0.
      m_scl_oe = 1'b0;
      m_sda_oe = 1'b0;
      push_g(4'b0100, 2'd2, -1);
      to_q.push_back(100);
      push_g(4'b0001, 2'd0, 18);
      req = 4'b0101;
      wait_grant(4'b0001, 300);
      push_g(4'b0100, 2'd2, 18);
      req = 4'b0100;
      wait_grant(4'b0100, 100);

      // Asynchronous reset while active.
      m_scl_oe = 1'b1;
      m_sda_oe = 1'b1;
      #1;
      chk("pre_rst_scl_oe", 32'(bus_scl_oe), 32'(4'b0100));
      chk("pre_rst_m_scl_i", 32'(m_scl_i), 0);
      #2;
      rst_n = 1'b0;
      req = 4'b0000;
      #1;
      chk("async_grant", 32'(grant), 0);
      chk("async_scl_oe", 32'(bus_scl_oe), 0);
      chk("async_sda_oe", 32'(bus_sda_oe), 0);
      chk("async_m_scl_i", 32'(m_scl_i), 1);
      chk("async_sel", 32'(sel), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("grants_left", exp_q.size(), 0);
      chk("timeouts_left", to_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
